trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap controller directly upstream of the CSR unit. Feeds the CSR exception override: csr_exception, csr_exception_cause, csr_exception_pc.
- Consumes the CSR control outputs: csr_interrupt_en, csr_mie, csr_mtvec_mode/base, csr_mepc.
- Arbitrates synchronous exceptions, interrupts and mret from the pipeline. Flushes the pipeline and issues a PC redirect with a valid/ready handshake to fetch.

Parameters:
- IRQ_SYNC_STAGES, 2, depth of the interrupt-line synchroniser; used only when TRAP_IRQ_SYNC_EN is defined; legal range 2..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  the instruction at ex_pc has an exception flag valid this cycle.
- ex_illegal  in  1  illegal instruction.
- ex_ebreak  in  1  ebreak.
- ex_ecall  in  1  ecall.
- ex_pc  in  WORD_W  pc of the faulting instruction.
- mret  in  1  mret retiring this cycle.
- int_pc_valid  in  1  int_pc is the oldest non-committed instruction (interrupt boundary).
- int_pc  in  WORD_W  pc to save on interrupt.
- irq_sw, irq_timer, irq_ext  in  1 each  interrupt lines.
- csr_interrupt_en  in  1  global MIE.
- csr_mie  in  WORD_W  interrupt enables; bits 3, 7, 11 are used.
- csr_mtvec_mode  in  2  trap vector mode.
- csr_mtvec_base  in  30  trap vector base.
- csr_mepc  in  WORD_W  mret target.
- csr_exception  out  1  one-cycle trap-entry pulse to the CSR unit.
- csr_exception_cause  out  WORD_W  mcause value.
- csr_exception_pc  out  WORD_W  mepc value.
- flush  out  1  squash all in-flight instructions.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  WORD_W  new fetch pc.
- redirect_ready  in  1  fetch accepts the redirect.
- busy  out  1  state is not IDLE; the pipeline must stall issue.

Behaviour:
- Reset: state=IDLE; all outputs 0, including cause, pc and redirect_pc.
- States: IDLE, FLUSH, REDIRECT.
- IDLE event priority:
  1. Exception: ex_valid and any flag set. Flag priority is ebreak (cause 3), then ecall (cause 11), then illegal (cause 2).
  2. Interrupt: pend = {irq_ext&mie[11], irq_sw&mie[3], irq_timer&mie[7]}, gated by csr_interrupt_en and int_pc_valid. Priority ext (11), then sw (3), then timer (7). Cause has bit 31 set.
  3. mret.
- IDLE with ex_valid and no flag set: no event.
- Trap taken (exception or interrupt):
  - Next cycle: csr_exception=1 for exactly one cycle.
  - cause/pc registered: pc is ex_pc for exceptions, int_pc for interrupts.
  - flush=1 for the same cycle; state goes to FLUSH.
  - Target computed: mode==1 and interrupt gives {base,2'b00} + (cause[4:0]<<2). Otherwise the target is {base,2'b00}. Addition wraps modulo 2^WORD_W.
  - Target uses mtvec sampled in the event cycle.
- mret taken: flush=1 for one cycle; target=csr_mepc sampled in the event cycle; state goes to FLUSH. csr_exception stays 0.
- FLUSH -> REDIRECT after 1 cycle. redirect_valid=1, redirect_pc=target.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until redirect_ready.
  - On ready, redirect_valid clears next cycle and state returns to IDLE.
  - Ready already high on the first REDIRECT cycle: single-cycle handshake.
- Minimum trap-to-IDLE latency: 3 cycles after the event cycle.
- busy=1 in FLUSH and REDIRECT.
- All ex_*, mret and irq inputs are ignored while busy. Levels still asserted on return to IDLE are re-evaluated.
- Simultaneous exception and mret: the exception wins; mret is dropped.
- Exception and interrupt in the same cycle: the exception wins; the interrupt stays pending as a level.
- csr_exception_cause and csr_exception_pc hold their last values after the pulse.
- rst in any state: IDLE next cycle, all outputs 0, and no pending redirect survives.

Optional Feature:
- Macro TRAP_IRQ_SYNC_EN.
- Defined: irq_sw/timer/ext each pass through an IRQ_SYNC_STAGES-deep flop chain, reset to 0, before pending logic. Interrupt latency grows by IRQ_SYNC_STAGES cycles.
- Undefined: lines are used combinationally and assumed synchronous to clk.

Decomposition:
- common_types_pkg gains:
  - typedef enum trap_state_t {IDLE, FLUSH, REDIRECT}.
  - Cause constants: CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_ECALL_M=11, CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11.
  - INT_BIT=31.
  - MTVEC_VECTORED=2'd1.
- word_t and WORD_W are reused.
- One sub-module: irq_sync, a parameterised flop chain instantiated three times under TRAP_IRQ_SYNC_EN.

Test Plan:
- Reset mid-REDIRECT (redirect_ready=0) -> next cycle state IDLE, redirect_valid=0, flush=0, csr_exception=0.
- ex_valid, ex_illegal, ex_pc=0x0000_0104, mtvec base=0x0000_0400>>2, mode 0 -> 1-cycle csr_exception, cause=2, pc=0x104; 2 cycles later redirect_pc=0x0000_0400.
- irq_timer=1, mie[7]=1, interrupt_en=1, int_pc=0x200, mode 1, base 0x1000>>2 -> cause=0x8000_0007, redirect_pc=0x0000_101C.
- Same cycle ex_ecall (ex_pc=0x300), irq_ext (mie[11]=1), and mret -> cause=11, pc=0x300. irq_ext still high afterward -> second trap, cause=0x8000_000B, on return to IDLE.
- mret with csr_mepc=0x0000_0500, redirect_ready low for 3 cycles -> csr_exception stays 0; redirect_pc held at 0x500 with redirect_valid=1 until ready.
- irq_sw=1 with interrupt_en=0, or with mie[3]=0 -> no trap, busy=0. Under TRAP_IRQ_SYNC_EN with all enables set, the trap fires IRQ_SYNC_STAGES cycles later.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared word type plus trap-controller state, cause codes and mtvec mode encodings.
package common_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} trap_state_t;

  localparam word_t CAUSE_ILLEGAL = 32'd2;
  localparam word_t CAUSE_BREAK   = 32'd3;
  localparam word_t CAUSE_ECALL_M = 32'd11;
  localparam word_t CAUSE_MSI     = 32'd3;
  localparam word_t CAUSE_MTI     = 32'd7;
  localparam word_t CAUSE_MEI     = 32'd11;

  localparam int         INT_BIT        = 31;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;
endpackage

// File: rtl/irq_sync.sv
// Reset-to-zero flop chain that brings an asynchronous interrupt line into the clk domain.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates exceptions, interrupts and mret, flushes and redirects fetch.
// Optional TRAP_IRQ_SYNC_EN adds an IRQ_SYNC_STAGES-deep synchroniser on each interrupt line.
module trap_ctrl
  import common_types_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_illegal,
  input  logic              ex_ebreak,
  input  logic              ex_ecall,
  input  logic [WORD_W-1:0] ex_pc,
  input  logic              mret,
  input  logic              int_pc_valid,
  input  logic [WORD_W-1:0] int_pc,
  input  logic              irq_sw,
  input  logic              irq_timer,
  input  logic              irq_ext,
  input  logic              csr_interrupt_en,
  input  logic [WORD_W-1:0] csr_mie,
  input  logic [1:0]        csr_mtvec_mode,
  input  logic [29:0]       csr_mtvec_base,
  input  logic [WORD_W-1:0] csr_mepc,
  output logic              csr_exception,
  output logic [WORD_W-1:0] csr_exception_cause,
  output logic [WORD_W-1:0] csr_exception_pc,
  output logic              flush,
  output logic              redirect_valid,
  output logic [WORD_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              busy
);
  if (IRQ_SYNC_STAGES < 2 || IRQ_SYNC_STAGES > 3) begin : g_bad_sync_depth
    $error("trap_ctrl: IRQ_SYNC_STAGES must be 2..3");
  end

  logic irq_sw_s, irq_timer_s, irq_ext_s;
`ifdef TRAP_IRQ_SYNC_EN
  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_sw    (.clk(clk), .rst(rst), .d(irq_sw),    .q(irq_sw_s));
  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_timer (.clk(clk), .rst(rst), .d(irq_timer), .q(irq_timer_s));
  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_ext   (.clk(clk), .rst(rst), .d(irq_ext),   .q(irq_ext_s));
`else
  assign irq_sw_s    = irq_sw;
  assign irq_timer_s = irq_timer;
  assign irq_ext_s   = irq_ext;
`endif

  logic unused_mie;
  assign unused_mie = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0]};

  logic [2:0] pend;
  logic       exc_take, irq_take;
  word_t      exc_cause, irq_cause, vec_base, vec_off, irq_target;

  assign pend     = {irq_ext_s & csr_mie[11], irq_sw_s & csr_mie[3], irq_timer_s & csr_mie[7]};
  assign exc_take = ex_valid & (ex_ebreak | ex_ecall | ex_illegal);
  assign irq_take = csr_interrupt_en & int_pc_valid & (|pend);
  assign vec_base = {csr_mtvec_base, 2'b00};

  always_comb begin
    exc_cause = CAUSE_ILLEGAL;
    if (ex_ebreak)     exc_cause = CAUSE_BREAK;
    else if (ex_ecall) exc_cause = CAUSE_ECALL_M;

    irq_cause = CAUSE_MTI;
    if (pend[2])      irq_cause = CAUSE_MEI;
    else if (pend[1]) irq_cause = CAUSE_MSI;
    irq_cause[INT_BIT] = 1'b1;

    // Vectored mode offsets by 4*code; wraps naturally at WORD_W bits.
    vec_off      = '0;
    vec_off[6:2] = irq_cause[4:0];
    irq_target   = (csr_mtvec_mode == MTVEC_VECTORED) ? vec_base + vec_off : vec_base;
  end

  trap_state_t state;
  word_t       target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      target              <= '0;
      csr_exception       <= 1'b0;
      csr_exception_cause <= '0;
      csr_exception_pc    <= '0;
      flush               <= 1'b0;
      redirect_valid      <= 1'b0;
      redirect_pc         <= '0;
      busy                <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_take) begin
            csr_exception       <= 1'b1;
            csr_exception_cause <= exc_cause;
            csr_exception_pc    <= ex_pc;
            flush               <= 1'b1;
            busy                <= 1'b1;
            target              <= vec_base;
            state               <= FLUSH;
          end else if (irq_take) begin
            csr_exception       <= 1'b1;
            csr_exception_cause <= irq_cause;
            csr_exception_pc    <= int_pc;
            flush               <= 1'b1;
            busy                <= 1'b1;
            target              <= irq_target;
            state               <= FLUSH;
          end else if (mret) begin
            flush  <= 1'b1;
            busy   <= 1'b1;
            target <= csr_mepc;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          csr_exception  <= 1'b0;
          flush          <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= target;
          state          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a behavioural model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_trap_ctrl;
`ifdef TRAP_IRQ_SYNC_EN
  localparam int SYNC_N = 2;
`else
  localparam int SYNC_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_illegal, ex_ebreak, ex_ecall, mret, int_pc_valid;
  logic [31:0] ex_pc, int_pc, csr_mie, csr_mepc;
  logic        irq_sw, irq_timer, irq_ext, csr_interrupt_en, redirect_ready;
  logic [1:0]  csr_mtvec_mode;
  logic [29:0] csr_mtvec_base;
  logic        csr_exception, flush, redirect_valid, busy;
  logic [31:0] csr_exception_cause, csr_exception_pc, redirect_pc;

  always #5 clk = ~clk;

  trap_ctrl #(.IRQ_SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_illegal(ex_illegal), .ex_ebreak(ex_ebreak), .ex_ecall(ex_ecall),
    .ex_pc(ex_pc), .mret(mret), .int_pc_valid(int_pc_valid), .int_pc(int_pc),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .csr_interrupt_en(csr_interrupt_en), .csr_mie(csr_mie),
    .csr_mtvec_mode(csr_mtvec_mode), .csr_mtvec_base(csr_mtvec_base), .csr_mepc(csr_mepc),
    .csr_exception(csr_exception), .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc(csr_exception_pc), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = free to accept an event, 1 = squash cycle, 2 = waiting on fetch.
  int          m_ph;
  logic        m_exc, m_flush, m_rv, m_busy;
  logic [31:0] m_cause, m_pc, m_rpc, m_tgt;
  logic [2:0]  hist [0:3];
  bit          model_live = 1'b0;

  always @(posedge clk) begin : model
    logic [2:0]  now, eff, pend;
    logic        exc, irq;
    logic [31:0] base;
    int          ecode, icode;
    now = {irq_ext, irq_sw, irq_timer};
    eff = (SYNC_N == 0) ? now : hist[(SYNC_N == 0) ? 0 : SYNC_N - 1];
    for (int k = 3; k > 0; k--) hist[k] = rst ? 3'b0 : hist[k-1];
    hist[0] = rst ? 3'b0 : now;
    if (rst) begin
      m_ph = 0; m_exc = 0; m_flush = 0; m_rv = 0; m_busy = 0;
      m_cause = 0; m_pc = 0; m_rpc = 0; m_tgt = 0;
      model_live = 1'b1;
    end else if (m_ph == 0) begin
      exc   = ex_valid && (ex_ebreak || ex_ecall || ex_illegal);
      pend  = {eff[2] & csr_mie[11], eff[1] & csr_mie[3], eff[0] & csr_mie[7]};
      irq   = csr_interrupt_en && int_pc_valid && (pend != 3'b0);
      ecode = ex_ebreak ? 3 : (ex_ecall ? 11 : 2);
      icode = pend[2] ? 11 : (pend[1] ? 3 : 7);
      base  = {csr_mtvec_base, 2'b00};
      if (exc) begin
        m_exc = 1; m_flush = 1; m_busy = 1; m_ph = 1;
        m_cause = 32'(ecode); m_pc = ex_pc; m_tgt = base;
      end else if (irq) begin
        m_exc = 1; m_flush = 1; m_busy = 1; m_ph = 1;
        m_cause = 32'h8000_0000 + 32'(icode); m_pc = int_pc;
        m_tgt = (csr_mtvec_mode == 2'd1) ? base + 32'(4 * icode) : base;
      end else if (mret) begin
        m_flush = 1; m_busy = 1; m_ph = 1; m_tgt = csr_mepc;
      end
    end else if (m_ph == 1) begin
      m_exc = 0; m_flush = 0; m_rv = 1; m_rpc = m_tgt; m_ph = 2;
    end else if (redirect_ready) begin
      m_rv = 0; m_busy = 0; m_ph = 0;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("mdl_exc",   32'(csr_exception),  32'(m_exc));
      check("mdl_cause", csr_exception_cause, m_cause);
      check("mdl_pc",    csr_exception_pc,    m_pc);
      check("mdl_flush", 32'(flush),          32'(m_flush));
      check("mdl_rv",    32'(redirect_valid), 32'(m_rv));
      check("mdl_rpc",   redirect_pc,         m_rpc);
      check("mdl_busy",  32'(busy),           32'(m_busy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_events();
    ex_valid = 0; ex_illegal = 0; ex_ebreak = 0; ex_ecall = 0; mret = 0;
  endtask

  task automatic wait_exc(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!csr_exception && n < max);
  endtask

  task automatic finish_redirect(input int holds, input logic [31:0] exp_pc);
    repeat (holds) begin
      step(1);
      check("hold_rv", 32'(redirect_valid), 32'd1);
      check("hold_rpc", redirect_pc, exp_pc);
    end
    redirect_ready = 1;
    step(1);
    check("done_rv", 32'(redirect_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1; clear_events();
    ex_pc = 0; int_pc = 0; int_pc_valid = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
    csr_interrupt_en = 0; csr_mie = 0; csr_mtvec_mode = 0; csr_mtvec_base = 0; csr_mepc = 0;
    redirect_ready = 0;
    step(2);
    check("rst_exc",   32'(csr_exception), 0);
    check("rst_cause", csr_exception_cause, 0);
    check("rst_rv",    32'(redirect_valid), 0);
    check("rst_rpc",   redirect_pc, 0);
    check("rst_busy",  32'(busy), 0);
    rst = 0;

    // Illegal instruction, direct mode.
    redirect_ready = 1; csr_mtvec_base = 30'h100; csr_mtvec_mode = 2'd0;
    ex_valid = 1; ex_illegal = 1; ex_pc = 32'h104;
    step(1);
    check("ill_exc",   32'(csr_exception), 1);
    check("ill_cause", csr_exception_cause, 32'd2);
    check("ill_pc",    csr_exception_pc, 32'h104);
    check("ill_flush", 32'(flush), 1);
    clear_events();
    step(1);
    check("ill_pulse_end", 32'(csr_exception), 0);
    check("ill_rv",  32'(redirect_valid), 1);
    check("ill_rpc", redirect_pc, 32'h400);
    step(1);
    check("ill_idle", 32'(busy), 0);

    // ex_valid without a flag is not an event.
    ex_valid = 1; step(2);
    check("noflag_busy", 32'(busy), 0);
    clear_events();

    // Flag priority: ebreak over ecall over illegal.
    ex_valid = 1; ex_ebreak = 1; ex_ecall = 1; ex_illegal = 1; ex_pc = 32'h108;
    step(1);
    check("prio_cause", csr_exception_cause, 32'd3);
    clear_events(); step(3);

    // Timer interrupt, vectored mode.
    redirect_ready = 0; csr_mie = 32'h80; csr_interrupt_en = 1; int_pc_valid = 1;
    int_pc = 32'h200; csr_mtvec_mode = 2'd1; csr_mtvec_base = 30'h400; irq_timer = 1;
    wait_exc(12, n);
    check("tmr_lat",   32'(n), 32'(1 + SYNC_N));
    check("tmr_cause", csr_exception_cause, 32'h8000_0007);
    check("tmr_pc",    csr_exception_pc, 32'h200);
    irq_timer = 0;
    step(1);
    check("tmr_rpc", redirect_pc, 32'h101C);
    finish_redirect(3, 32'h101C);

    // ecall + ext irq + mret in one cycle; ext irq traps on return to idle.
    csr_mie = 32'h800; int_pc = 32'h240; csr_mepc = 32'h500;
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h300; irq_ext = 1; mret = 1;
    step(1);
    check("mix_cause", csr_exception_cause, 32'd11);
    check("mix_pc",    csr_exception_pc, 32'h300);
    clear_events();
    wait_exc(12, n);
    check("mix2_gap",   32'(n), 32'd3);
    check("mix2_cause", csr_exception_cause, 32'h8000_000B);
    check("mix2_pc",    csr_exception_pc, 32'h240);
    redirect_ready = 0; irq_ext = 0;
    step(1);
    check("mix2_rpc", redirect_pc, 32'h102C);
    finish_redirect(3, 32'h102C);

    // mret with fetch stalled.
    redirect_ready = 0; mret = 1;
    step(1);
    check("mret_flush", 32'(flush), 1);
    check("mret_exc",   32'(csr_exception), 0);
    mret = 0;
    step(1);
    check("mret_rv",  32'(redirect_valid), 1);
    check("mret_rpc", redirect_pc, 32'h500);
    check("mret_cause_hold", csr_exception_cause, 32'h8000_000B);
    finish_redirect(3, 32'h500);

    // Software interrupt masked globally, then by mie.
    irq_sw = 1; csr_mie = 32'h8; csr_interrupt_en = 0;
    repeat (5) begin step(1); check("sw_gie_busy", 32'(busy), 0); end
    csr_interrupt_en = 1; csr_mie = 32'h880;
    repeat (5) begin step(1); check("sw_mie_busy", 32'(busy), 0); end
    irq_sw = 0; step(4);
    csr_mie = 32'h888; csr_mtvec_mode = 2'd0; int_pc = 32'h280; irq_sw = 1;
    wait_exc(12, n);
    check("sw_lat",   32'(n), 32'(1 + SYNC_N));
    check("sw_cause", csr_exception_cause, 32'h8000_0003);
    irq_sw = 0; redirect_ready = 0;
    step(1);
    check("sw_rpc", redirect_pc, 32'h1000);
    finish_redirect(3, 32'h1000);

    // Reset while waiting on fetch drops the redirect.
    redirect_ready = 0; step(4);
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h310;
    step(1); clear_events(); step(1);
    check("rr_pre_rv", 32'(redirect_valid), 1);
    rst = 1; step(1);
    check("rr_rv",    32'(redirect_valid), 0);
    check("rr_flush", 32'(flush), 0);
    check("rr_exc",   32'(csr_exception), 0);
    check("rr_busy",  32'(busy), 0);
    check("rr_rpc",   redirect_pc, 0);
    rst = 0; redirect_ready = 1; step(3);
    check("rr_after_rv", 32'(redirect_valid), 0);
    check("rr_after_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
